data_memory_controller: RTL and testbench
=========================================

Name: data_memory_controller

Overview:
- Data-memory slave for the pipelined RV32I CPU core. Serves the core's MEM-stage load/store requests.
- Owns a word-organised SRAM array. Performs byte/half/word lane selection, and sign or zero extension on loads.
- Stalls the pipeline via BUSYWAIT for a fixed, parameterised access latency.
- Sits directly downstream of the CPU data-memory port and drives its READ_DATA/BUSYWAIT inputs.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2**ADDR_WIDTH 32-bit words.
- ACCESS_LATENCY, 3, number of cycles BUSYWAIT is held high per access; legal range 1..15.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  4  bit3 = load request; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- WRITE  input  3  bit2 = store request; [1:0] = funct3[1:0] (00 SB, 01 SH, 10 SW).
- ADDR  input  32  byte address.
- WRITE_DATA  input  32  store data; the low byte/half is used for SB/SH.
- READ_DATA  output  32  load result; valid in the DONE cycle, held until the next load completes.
- BUSYWAIT  output  1  stall request to the CPU.
- MISALIGNED  output  1  one-cycle flag in the DONE cycle of a misaligned access.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, BUSYWAIT=0, READ_DATA=0, MISALIGNED=0, counter=0.
  - Array contents are not cleared; any in-flight access is abandoned and no write occurs.
- Request detection: req = READ[3] | WRITE[2]. If both are set, the store wins, the load is ignored and READ_DATA keeps its value.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - BUSYWAIT = req, combinational, so the CPU stalls in the same cycle the request appears.
  - On an edge with req: latch ADDR, WRITE_DATA, opcode. If ACCESS_LATENCY=1, perform the access and go to DONE. Otherwise load counter=ACCESS_LATENCY-1 and go to BUSY.
- BUSY:
  - BUSYWAIT=1; counter decrements each edge.
  - On the edge where counter==1, perform the access using the latched values and go to DONE.
- DONE:
  - BUSYWAIT=0; READ_DATA (for loads) and MISALIGNED are valid.
  - The CPU advances on the edge ending DONE. Next state is always IDLE; the request still present in DONE is the old one and is never re-launched.
- Timing: request first seen in cycle 0, BUSYWAIT high in cycles 0..ACCESS_LATENCY-1, low in cycle ACCESS_LATENCY (DONE). A request presented in the first IDLE cycle after DONE is treated as new.
- The CPU holds the request stable while BUSYWAIT=1; changes to the inputs after acceptance are ignored.
- Addressing:
  - word index = ADDR[ADDR_WIDTH+1:2]; upper bits are ignored, so addresses wrap modulo the depth.
  - byte lane = ADDR[1:0]; little-endian, so lane 0 = bits [7:0].
- Loads:
  - LB/LBU select the byte at the lane; LH/LHU select the half at ADDR[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW returns the whole word.
  - Undefined funct3 (011, 110, 111) is treated as LW.
- Stores:
  - SB writes one lane; SH writes lanes {1,0} or {3,2}; SW writes all lanes; other lanes are preserved.
  - WRITE[1:0]=11 is treated as SW.
- Misalignment: an LH/LHU/SH with ADDR[0]=1, or an LW/SW with ADDR[1:0]!=0, completes with normal timing but:
  - no array write occurs;
  - READ_DATA is set to 0 for loads;
  - MISALIGNED=1 for the DONE cycle only.
- Reset asserted during BUSY: immediate return to IDLE with BUSYWAIT=0; the pending store is dropped.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> BUSYWAIT high exactly 3 cycles each (default latency); READ_DATA=0xDEADBEEF in DONE.
- After the above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x55 to 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF; SH 0x1234 to 0x12, then LW -> 0x123455EF.
- LW 0x11 and SH 0x13 -> MISALIGNED pulses 1 cycle, READ_DATA=0, word at 0x10 unchanged.
- Back-to-back: LW 0x10 held through DONE then immediately LW 0x14 -> two separate 3-cycle stalls with exactly one BUSYWAIT-low cycle between. ACCESS_LATENCY=1 build -> one busy cycle per access.
- SW 0xFFFFFFFF to 0x10 with RESET pulsed low in BUSY cycle 1 -> BUSYWAIT drops asynchronously, READ_DATA=0, subsequent LW 0x10 returns the old value 0x123455EF.

Source files
------------

// File: rtl/data_memory_controller.sv
// Data-memory slave for the RV32I MEM stage: word-organised SRAM with byte/half/word
// lane selection, load sign/zero extension and a fixed BUSYWAIT access latency.
module data_memory_controller #(
  parameter int ADDR_WIDTH     = 10,
  parameter int ACCESS_LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int AW    = ADDR_WIDTH + 2;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_launch;
  logic            w_fire;
  logic            w_busy;

  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic            r_store;
  logic            r_load;
  logic [2:0]      r_lop;
  logic [1:0]      r_sop;

  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_in_store;
  logic            w_in_load;

  // Operands of the access being performed this edge: live inputs when a
  // single-cycle access fires straight from IDLE, latched copies otherwise.
  logic [AW-1:0]   w_a_addr;
  logic [31:0]     w_a_wdata;
  logic            w_a_store;
  logic            w_a_load;
  logic [2:0]      w_a_lop;
  logic [1:0]      w_a_sop;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]      w_lane;
  logic [31:0]     w_word;
  logic            w_sz_byte;
  logic            w_sz_half;
  logic            w_mis;
  logic [7:0]      w_lbyte;
  logic [15:0]     w_lhalf;
  logic            w_lsign;
  logic [31:0]     w_ldata;
  logic [3:0]      w_wmask;
  logic [31:0]     w_wword;

  generate
    if (AW < 32) begin : g_unused_addr
      logic w_unused_addr;
      assign w_unused_addr = ^ADDR[31:AW];
    end
  endgenerate

  assign w_in_store = WRITE[2];
  assign w_in_load  = READ[3] & ~WRITE[2];
  assign w_req      = READ[3] | WRITE[2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    w_launch    = 1'b0;
    w_fire      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = w_req;
        if (w_req) begin
          w_launch = 1'b1;
          if (ACCESS_LATENCY == 1) begin
            w_fire      = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = 4'(ACCESS_LATENCY - 1);
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_fire      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Gated by RESET so the stall drops asynchronously while the CPU still holds its request.
  assign BUSYWAIT = RESET & w_busy;

  always_comb begin
    if (r_state == S_IDLE) begin
      w_a_addr  = ADDR[AW-1:0];
      w_a_wdata = WRITE_DATA;
      w_a_store = w_in_store;
      w_a_load  = w_in_load;
      w_a_lop   = READ[2:0];
      w_a_sop   = WRITE[1:0];
    end else begin
      w_a_addr  = r_addr;
      w_a_wdata = r_wdata;
      w_a_store = r_store;
      w_a_load  = r_load;
      w_a_lop   = r_lop;
      w_a_sop   = r_sop;
    end
  end

  always_comb begin
    w_idx  = w_a_addr[AW-1:2];
    w_lane = w_a_addr[1:0];
    w_word = r_mem[w_idx];

    if (w_a_store) begin
      w_sz_byte = (w_a_sop == 2'b00);
      w_sz_half = (w_a_sop == 2'b01);
    end else begin
      w_sz_byte = (w_a_lop[1:0] == 2'b00);
      w_sz_half = (w_a_lop[1:0] == 2'b01);
    end

    if (w_sz_half) begin
      w_mis = w_lane[0];
    end else if (w_sz_byte) begin
      w_mis = 1'b0;
    end else begin
      w_mis = (w_lane != 2'b00);
    end

    w_lbyte = w_word[{w_lane, 3'b000} +: 8];
    w_lhalf = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_lsign = ~w_a_lop[2];
    if (w_sz_byte) begin
      w_ldata = {{24{w_lsign & w_lbyte[7]}}, w_lbyte};
    end else if (w_sz_half) begin
      w_ldata = {{16{w_lsign & w_lhalf[15]}}, w_lhalf};
    end else begin
      w_ldata = w_word;
    end

    if (w_sz_byte) begin
      w_wmask = 4'b0001 << w_lane;
      w_wword = {4{w_a_wdata[7:0]}};
    end else if (w_sz_half) begin
      w_wmask = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wword = {2{w_a_wdata[15:0]}};
    end else begin
      w_wmask = 4'b1111;
      w_wword = w_a_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && w_fire && w_a_store && !w_mis) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_wword[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_store    <= 1'b0;
      r_load     <= 1'b0;
      r_lop      <= '0;
      r_sop      <= '0;
      READ_DATA  <= '0;
      MISALIGNED <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      MISALIGNED <= w_fire & w_mis;
      if (w_launch) begin
        r_addr  <= ADDR[AW-1:0];
        r_wdata <= WRITE_DATA;
        r_store <= w_in_store;
        r_load  <= w_in_load;
        r_lop   <= READ[2:0];
        r_sop   <= WRITE[1:0];
      end
      if (w_fire && w_a_load) begin
        READ_DATA <= w_mis ? '0 : w_ldata;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: directed and random loads/stores on a
// latency-3 and a latency-1 instance, checked against a byte-addressed model.
module tb_data_memory_controller;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rd3, rd1;
  logic [2:0]  wr3, wr1;
  logic [31:0] ad3, ad1, wd3, wd1;
  logic [31:0] rdata3, rdata1;
  logic        busy3, busy1, mis3, mis1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mb [2][4096];
  logic [31:0] last [2];

  data_memory_controller #(.ADDR_WIDTH(10), .ACCESS_LATENCY(3)) u_dut3 (
    .CLK(clk), .RESET(rst_n), .READ(rd3), .WRITE(wr3), .ADDR(ad3),
    .WRITE_DATA(wd3), .READ_DATA(rdata3), .BUSYWAIT(busy3), .MISALIGNED(mis3)
  );

  data_memory_controller #(.ADDR_WIDTH(10), .ACCESS_LATENCY(1)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .READ(rd1), .WRITE(wr1), .ADDR(ad1),
    .WRITE_DATA(wd1), .READ_DATA(rdata1), .BUSYWAIT(busy1), .MISALIGNED(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic int sz_load(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int sz_store(input logic [1:0] sf);
    case (sf)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic model_mis(input bit st, input logic [2:0] f3,
                                     input logic [1:0] sf, input logic [31:0] a);
    int sz;
    sz = st ? sz_store(sf) : sz_load(f3);
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = sz_load(f3);
    v  = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = mb[d][(a + k) & 32'hFFF];
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 1);
    return v;
  endfunction

  task automatic model_store(input int d, input logic [1:0] sf, input logic [31:0] a, input logic [31:0] wd);
    int sz;
    sz = sz_store(sf);
    for (int k = 0; k < sz; k++) mb[d][(a + k) & 32'hFFF] = wd[8*k +: 8];
  endtask

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy3 : busy1;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? rdata3 : rdata1;
  endfunction

  function automatic logic mis_of(input int d);
    return (d == 0) ? mis3 : mis1;
  endfunction

  task automatic drive(input int d, input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      rd3 = rd; wr3 = wr; ad3 = a; wd3 = wd;
    end else begin
      rd1 = rd; wr1 = wr; ad1 = a; wd1 = wd;
    end
  endtask

  // Called just after a rising edge in an IDLE cycle; returns likewise.
  task automatic access(input int d, input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    int   lat;
    int   n;
    bit   st;
    bit   ld;
    logic exp_mis;
    lat     = (d == 0) ? 3 : 1;
    st      = wr[2];
    ld      = rd[3] & ~wr[2];
    exp_mis = model_mis(st, rd[2:0], wr[1:0], a);
    if (ld) last[d] = exp_mis ? 32'h0 : model_load(d, rd[2:0], a);
    drive(d, rd, wr, a, wd);
    #1;
    n = 0;
    while (busy_of(d) === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(lat));
    check({tag, " read_data"}, rdata_of(d), last[d]);
    check({tag, " misaligned"}, {31'h0, mis_of(d)}, {31'h0, exp_mis});
    if (st && !exp_mis) model_store(d, wr[1:0], a, wd);
    @(posedge clk); #1;
    drive(d, 4'h0, 3'h0, 32'h0, 32'h0);
    check({tag, " mis_clear"}, {31'h0, mis_of(d)}, 32'h0);
  endtask

  initial begin
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          kind;

    rst_n = 1'b0;
    drive(0, 4'h0, 3'h0, 32'h0, 32'h0);
    drive(1, 4'h0, 3'h0, 32'h0, 32'h0);
    last[0] = '0;
    last[1] = '0;
    #12;
    check("reset busy3", {31'h0, busy3}, 32'h0);
    check("reset rdata3", rdata3, 32'h0);
    check("reset mis3", {31'h0, mis3}, 32'h0);
    check("reset rdata1", rdata1, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) access(0, 4'h0, 3'b110, 32'(i*4), $urandom, "init3");
    for (int i = 0; i < 4; i++)  access(1, 4'h0, 3'b110, 32'(i*4), $urandom, "init1");

    access(0, 4'h0,    3'b110, 32'h10, 32'hDEADBEEF, "sw10");
    access(0, 4'b1010, 3'h0,   32'h10, 32'h0, "lw10");
    check("lw10 const", rdata3, 32'hDEADBEEF);
    access(0, 4'b1000, 3'h0, 32'h13, 32'h0, "lb13");
    check("lb13 const", rdata3, 32'hFFFFFFDE);
    access(0, 4'b1100, 3'h0, 32'h13, 32'h0, "lbu13");
    check("lbu13 const", rdata3, 32'h000000DE);
    access(0, 4'b1001, 3'h0, 32'h10, 32'h0, "lh10");
    check("lh10 const", rdata3, 32'hFFFFBEEF);
    access(0, 4'b1101, 3'h0, 32'h12, 32'h0, "lhu12");
    check("lhu12 const", rdata3, 32'h0000DEAD);
    access(0, 4'h0,    3'b100, 32'h11, 32'h00000055, "sb11");
    access(0, 4'b1010, 3'h0,   32'h10, 32'h0, "lw_after_sb");
    check("sb merge const", rdata3, 32'hDEAD55EF);
    access(0, 4'h0,    3'b101, 32'h12, 32'h00001234, "sh12");
    access(0, 4'b1010, 3'h0,   32'h10, 32'h0, "lw_after_sh");
    check("sh merge const", rdata3, 32'h123455EF);
    access(0, 4'b1010, 3'h0,   32'h11, 32'h0, "lw11_mis");
    access(0, 4'h0,    3'b101, 32'h13, 32'hFFFFFFFF, "sh13_mis");
    access(0, 4'b1010, 3'h0,   32'h10, 32'h0, "lw_after_mis");
    check("mis no write", rdata3, 32'h123455EF);
    access(0, 4'b1010, 3'b110, 32'h18, 32'hA5A5A5A5, "store_wins");
    access(0, 4'b1011, 3'h0,   32'h10, 32'h0, "f3_011_as_lw");
    access(0, 4'b1010, 3'h0,   32'h1010, 32'h0, "wrap");
    access(0, 4'b1010, 3'h0,   32'h10, 32'h0, "b2b_a");
    access(0, 4'b1010, 3'h0,   32'h14, 32'h0, "b2b_b");

    drive(0, 4'h0, 3'b110, 32'h10, 32'hFFFFFFFF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst busy drop", {31'h0, busy3}, 32'h0);
    check("rst rdata3", rdata3, 32'h0);
    check("rst rdata1", rdata1, 32'h0);
    drive(0, 4'h0, 3'h0, 32'h0, 32'h0);
    last[0] = '0;
    last[1] = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 4'b1010, 3'h0, 32'h10, 32'h0, "lw_after_rst");
    check("rst drop store", rdata3, 32'h123455EF);

    access(1, 4'h0,    3'b110, 32'h4, 32'hCAFEF00D, "l1_sw");
    access(1, 4'b1001, 3'h0,   32'h6, 32'h0, "l1_lh");
    access(1, 4'b1010, 3'h0,   32'h4, 32'h0, "l1_lw");

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      rd   = {kind != 0, 3'($urandom)};
      wr   = {kind != 1, 2'($urandom)};
      a    = ($urandom & 32'hFFFFF000) | $urandom_range(0, 63);
      wd   = $urandom;
      access(0, rd, wr, a, wd, "rnd3");
    end
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      rd   = {kind != 0, 3'($urandom)};
      wr   = {kind != 1, 2'($urandom)};
      a    = ($urandom & 32'hFFFFF000) | $urandom_range(0, 15);
      wd   = $urandom;
      access(1, rd, wr, a, wd, "rnd1");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
